// File: rtl/ccff_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccff_loader                                                              |
// | Serializes host words onto the ccff chain, then recirculates the chain   |
// | once and compares load/readback CRC-8 to flag chain faults.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ccff_loader #(
  parameter int CHAIN_LEN = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BCNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_bits;
  logic [CNT_W-1:0]    r_vcnt;
  logic [DATA_W-1:0]   r_buf;
  logic [BCNT_W-1:0]   r_buf_cnt;
  logic [7:0]          r_crc_load;
  logic [7:0]          r_crc_verify;
  logic                r_error;

  logic w_in_load;
  logic w_in_verify;
  logic w_room;
  logic w_ready;
  logic w_shift_load;
  logic w_accept;
  logic w_last_shift;
  logic w_last_verify;

  // CRC-8, poly x^8+x^2+x+1, MSB-first bit-serial update
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb        = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign w_in_load     = (r_state == ST_LOAD);
  assign w_in_verify   = (r_state == ST_VERIFY);
  assign w_room        = (int'(r_bits) + int'(r_buf_cnt)) < CHAIN_LEN;
  assign w_ready       = w_in_load && (r_buf_cnt <= BCNT_W'(1)) && w_room;
  assign w_shift_load  = w_in_load && (r_buf_cnt != '0);
  assign w_accept      = cfg_valid && w_ready;
  assign w_last_shift  = w_shift_load && (r_bits == c_last_idx);
  assign w_last_verify = w_in_verify && (r_vcnt == c_last_idx);

  assign cfg_ready     = w_ready;
  assign ccff_shift_en = w_shift_load || w_in_verify;
  // Readback loops the tail straight back to the head so contents survive
  assign ccff_head     = w_in_load ? r_buf[0] : (w_in_verify ? ccff_tail : 1'b0);
  assign busy          = w_in_load || w_in_verify;
  assign done          = (r_state == ST_DONE);
  assign error         = r_error;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_LOAD;
      ST_LOAD:   if (w_last_shift) w_state_next = ST_VERIFY;
      ST_VERIFY: if (w_last_verify) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      r_state      <= ST_IDLE;
      r_bits       <= '0;
      r_vcnt       <= '0;
      r_buf        <= '0;
      r_buf_cnt    <= '0;
      r_crc_load   <= '0;
      r_crc_verify <= '0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bits       <= '0;
            r_vcnt       <= '0;
            r_buf        <= '0;
            r_buf_cnt    <= '0;
            r_crc_load   <= '0;
            r_crc_verify <= '0;
            r_error      <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_shift_load) begin
            r_bits     <= r_bits + CNT_W'(1);
            r_crc_load <= crc8_step(r_crc_load, r_buf[0]);
          end
          // A new word may land on the same edge the last buffered bit leaves
          if (w_accept) begin
            r_buf     <= cfg_data;
            r_buf_cnt <= BCNT_W'(DATA_W);
          end else if (w_shift_load) begin
            r_buf     <= r_buf >> 1;
            r_buf_cnt <= r_buf_cnt - BCNT_W'(1);
          end
        end
        ST_VERIFY: begin
          r_vcnt       <= r_vcnt + CNT_W'(1);
          r_crc_verify <= crc8_step(r_crc_verify, ccff_tail);
        end
        ST_DONE: begin
          r_error <= (r_crc_load != r_crc_verify);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ccff_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ccff_loader                                                           |
// | Directed bench: three loaders (4, 20 and 1 bit chains) with chain models.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ccff_loader;

  logic clk = 1'b0;
  logic prog_reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT A: 4-bit chain
  logic       start_a = 1'b0, valid_a = 1'b0, stuck_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       ready_a, head_a, tail_a, shift_a, busy_a, done_a, error_a;
  logic [3:0] chain_a = '0;
  always @(posedge clk) if (shift_a) chain_a <= {chain_a[2:0], head_a};
  assign tail_a = stuck_a ? 1'b0 : chain_a[3];

  ccff_loader #(.CHAIN_LEN(4), .DATA_W(8)) u_a (
    .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_a),
    .cfg_data(data_a), .cfg_valid(valid_a), .cfg_ready(ready_a),
    .ccff_head(head_a), .ccff_tail(tail_a), .ccff_shift_en(shift_a),
    .busy(busy_a), .done(done_a), .error(error_a));

  // DUT B: 20-bit chain
  logic        start_b = 1'b0, valid_b = 1'b0;
  logic [7:0]  data_b = 8'h00;
  logic        ready_b, head_b, tail_b, shift_b, busy_b, done_b, error_b;
  logic [19:0] chain_b = '0;
  always @(posedge clk) if (shift_b) chain_b <= {chain_b[18:0], head_b};
  assign tail_b = chain_b[19];

  ccff_loader #(.CHAIN_LEN(20), .DATA_W(8)) u_b (
    .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_b),
    .cfg_data(data_b), .cfg_valid(valid_b), .cfg_ready(ready_b),
    .ccff_head(head_b), .ccff_tail(tail_b), .ccff_shift_en(shift_b),
    .busy(busy_b), .done(done_b), .error(error_b));

  // DUT C: single-bit chain
  logic       start_c = 1'b0, valid_c = 1'b0;
  logic [7:0] data_c = 8'h00;
  logic       ready_c, head_c, tail_c, shift_c, busy_c, done_c, error_c;
  logic       chain_c = 1'b0;
  always @(posedge clk) if (shift_c) chain_c <= head_c;
  assign tail_c = chain_c;

  ccff_loader #(.CHAIN_LEN(1), .DATA_W(8)) u_c (
    .prog_clk(clk), .prog_reset_n(prog_reset_n), .start(start_c),
    .cfg_data(data_c), .cfg_valid(valid_c), .cfg_ready(ready_c),
    .ccff_head(head_c), .ccff_tail(tail_c), .ccff_shift_en(shift_c),
    .busy(busy_c), .done(done_c), .error(error_c));

  // Handshake and done-pulse monitors, sampled mid-cycle
  int acc_a = 0, acc_b = 0, acc_c = 0, dn_a = 0;
  always @(negedge clk) begin
    if (valid_a && ready_a) acc_a++;
    if (valid_b && ready_b) acc_b++;
    if (valid_c && ready_c) acc_c++;
    if (done_a) dn_a++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full load/verify on A; returns done cycle (after E0) and error seen in cycle 0
  task automatic run_a(input logic [7:0] d, output int done_cyc, output logic err0);
    done_cyc = -1;
    @(negedge clk);
    start_a = 1'b1; valid_a = 1'b1; data_a = d;
    @(posedge clk); #1;
    start_a = 1'b0;
    err0 = error_a;
    for (int c = 0; c < 100; c++) begin
      if (done_a) begin done_cyc = c; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  // Streams 0x3C,0xF0,0x5A into B; optional 3-cycle host stall before word 1
  task automatic run_b(input int gap, output int done_cyc, output int sh_cnt, output int stall);
    logic [7:0] words [3];
    int idx, gap_left;
    logic seen;
    words[0] = 8'h3C; words[1] = 8'hF0; words[2] = 8'h5A;
    idx = 0; gap_left = gap; seen = 1'b0;
    done_cyc = -1; sh_cnt = 0; stall = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done_b) begin done_cyc = c; break; end
      if (shift_b) begin sh_cnt++; seen = 1'b1; end
      else if (seen && busy_b) stall++;
      if (idx < 3) begin
        if (idx == 1 && ready_b && gap_left > 0) begin
          valid_b = 1'b0;
          gap_left--;
        end else begin
          valid_b = 1'b1;
          data_b  = words[idx];
          if (ready_b) idx++;
        end
      end else begin
        valid_b = 1'b0;
      end
      @(posedge clk); #1;
    end
    valid_b = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic start; logic valid;
    logic ready; logic shift; logic head; logic busy; logic done;
  } vec_t;

  initial begin
    vec_t tbl [12];
    int   a0, d0, dc, sh, st;
    logic e0;

    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready_a, 0);
    chk("rst_shift", shift_a, 0);
    chk("rst_head",  head_a,  0);
    chk("rst_busy",  busy_a,  0);
    chk("rst_done",  done_a,  0);
    chk("rst_error", error_a, 0);
    @(posedge clk); #1;
    prog_reset_n = 1'b1;

    // cfg_valid in IDLE is not consumed
    a0 = acc_a; d0 = dn_a;
    valid_a = 1'b1; data_a = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_ready", ready_a, 0);
    chk("idle_acc", acc_a - a0, 0);

    // Cycle-by-cycle load of 0xA5 into the 4-bit chain, with ignored starts
    start_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start_a = tbl[i].start;
      valid_a = tbl[i].valid;
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), ready_a, tbl[i].ready);
      chk($sformatf("row%0d_shift", i), shift_a, tbl[i].shift);
      chk($sformatf("row%0d_head",  i), head_a,  tbl[i].head);
      chk($sformatf("row%0d_busy",  i), busy_a,  tbl[i].busy);
      chk($sformatf("row%0d_done",  i), done_a,  tbl[i].done);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_words", acc_a - a0, 1);
    chk("a_donecnt", dn_a - d0, 1);
    chk("a_chain", chain_a, 4'b1010);
    chk("a_error", error_a, 0);

    // Reset on the second LOAD shift aborts immediately
    @(negedge clk);
    start_a = 1'b1; valid_a = 1'b1; data_a = 8'hA5;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_shift", shift_a, 1);
    prog_reset_n = 1'b0;
    @(posedge clk); #1;
    prog_reset_n = 1'b1;
    valid_a = 1'b0;
    @(negedge clk);
    chk("abort_shift", shift_a, 0);
    chk("abort_busy",  busy_a,  0);
    chk("abort_ready", ready_a, 0);
    run_a(8'hA5, dc, e0);
    chk("reload_done_cyc", dc, 9);
    chk("reload_chain", chain_a, 4'b1010);
    chk("reload_error", error_a, 0);

    // Tail stuck at 0: error set, sticky, cleared by next start
    stuck_a = 1'b1;
    run_a(8'hFF, dc, e0);
    chk("stuck_done_cyc", dc, 9);
    chk("stuck_error", error_a, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stuck_sticky", error_a, 1);
    stuck_a = 1'b0;
    run_a(8'h5A, dc, e0);
    chk("clr_on_start", e0, 0);
    chk("clr_done_cyc", dc, 9);
    chk("clr_chain", chain_a, 4'b0101);
    chk("clr_error", error_a, 0);

    // 20-bit chain, three words, no host gaps
    a0 = acc_b;
    run_b(0, dc, sh, st);
    chk("b0_words", acc_b - a0, 3);
    chk("b0_done_cyc", dc, 41);
    chk("b0_shifts", sh, 40);
    chk("b0_stalls", st, 0);
    chk("b0_chain", chain_b, 20'h3C0F5);
    chk("b0_error", error_b, 0);

    // Same stream with a 3-cycle host stall
    chain_b = '0;
    a0 = acc_b;
    run_b(3, dc, sh, st);
    chk("b3_words", acc_b - a0, 3);
    chk("b3_done_cyc", dc, 44);
    chk("b3_shifts", sh, 40);
    chk("b3_stalls", st, 3);
    chk("b3_chain", chain_b, 20'h3C0F5);
    chk("b3_error", error_b, 0);

    // Single-bit chain: one shift, one verify
    a0 = acc_c; dc = -1;
    @(negedge clk);
    start_c = 1'b1; valid_c = 1'b1; data_c = 8'h03;
    @(posedge clk); #1;
    start_c = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done_c) begin dc = c; break; end
      @(posedge clk); #1;
    end
    valid_c = 1'b0;
    @(posedge clk); #1;
    chk("c_done_cyc", dc, 3);
    chk("c_words", acc_c - a0, 1);
    chk("c_chain", chain_c, 1);
    chk("c_error", error_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
